// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count_checker response monitor.
// Log entry layout, LSB first: actual, expected, stamp.
package count_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int unsigned STAMP_W = 16;
  localparam int unsigned ERR_W   = 16;

  localparam int unsigned LOG_ACT_LSB = 0;

  function automatic int unsigned log_exp_lsb(input int unsigned width);
    return width;
  endfunction

  function automatic int unsigned log_stamp_lsb(input int unsigned width);
    return 2 * width;
  endfunction

  function automatic int unsigned log_entry_w(input int unsigned width);
    return STAMP_W + 2 * width;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and simultaneous push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/count_checker.sv
// Response monitor for the load counter: predicts count_out each cycle,
// counts mismatches and logs {stamp, expected, actual} into a FIFO.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int unsigned WIDTH     = 10,
  parameter int unsigned LOG_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     load_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [WIDTH-1:0]         count_out,
  input  logic                     log_rd_en,
  output logic [16+2*WIDTH-1:0]    log_rd_data,
  output logic                     log_empty,
  output logic                     log_full,
  output logic                     log_overflow,
  output logic [15:0]              err_count,
  output logic                     checking
);

  localparam int unsigned ENTRY_W   = log_entry_w(WIDTH);
  localparam int unsigned EXP_LSB   = log_exp_lsb(WIDTH);
  localparam int unsigned STAMP_LSB = log_stamp_lsb(WIDTH);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   exp_q;
  logic [WIDTH-1:0]   model_next;
  logic [STAMP_W-1:0] stamp_q;
  logic [ERR_W-1:0]   err_q;
  logic               ovf_q;
  logic               chk_q;
  logic               mismatch;
  logic [ENTRY_W-1:0] entry;

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_SYNC;
        ST_SYNC:  state_d = ST_CHECK;
        ST_CHECK: state_d = ST_CHECK;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Prediction always starts from the observed count, so a single corrupt
  // sample produces one error instead of a run of them.
  assign model_next = load_en ? data_in : count_out + WIDTH'(1);
  assign mismatch   = (state_q == ST_CHECK) && enable && (count_out != exp_q);

  always_comb begin
    entry = '0;
    entry[LOG_ACT_LSB +: WIDTH]  = count_out;
    entry[EXP_LSB +: WIDTH]      = exp_q;
    entry[STAMP_LSB +: STAMP_W]  = stamp_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      stamp_q <= '0;
      err_q   <= '0;
      ovf_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chk_q   <= (state_d == ST_CHECK);
      stamp_q <= stamp_q + 1'b1;
      if (state_q == ST_SYNC || state_q == ST_CHECK) exp_q <= model_next;
      if (mismatch && err_q != '1) err_q <= err_q + 1'b1;
      if (mismatch && log_full && !log_rd_en) ovf_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk       (clk),
    .reset     (reset),
    .push      (mismatch),
    .push_data (entry),
    .pop       (log_rd_en),
    .pop_data  (log_rd_data),
    .empty     (log_empty),
    .full      (log_full)
  );

  assign err_count    = err_q;
  assign log_overflow = ovf_q;
  assign checking     = chk_q;

endmodule

// File: doc/count_checker.md
# count_checker

Self-checking response monitor for the 10-bit load counter: the receiving end of the counter's `count_out` interface. It watches the same `load_en`/`data_in` stimulus the counter sees, predicts the next `count_out` every cycle, counts mismatches, and logs each one into an internal FIFO that the bench or host drains. It sits beside the counter in the test top, replacing per-cycle file logging with an on-chip pass/fail record.

## Interface

Parameters:
- `WIDTH`, 10: counter/data width.
- `LOG_DEPTH`, 16: error-log FIFO entries; must be a power of 2, at least 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: checking enabled.
- `load_en` in 1: counter load strobe, as driven to the counter.
- `data_in` in WIDTH: counter load value, as driven to the counter.
- `count_out` in WIDTH: counter output under check.
- `log_rd_en` in 1: pop the log head; ignored when `log_empty`.
- `log_rd_data` out 16+2*WIDTH: head entry `{stamp[15:0], expected, actual}`, show-ahead.
- `log_empty` out 1: log FIFO empty.
- `log_full` out 1: log FIFO full.
- `log_overflow` out 1: sticky; a mismatch was dropped because the log was full.
- `err_count` out 16: mismatches detected, saturating at 0xFFFF.
- `checking` out 1: FSM is in CHECK.

## Operation

- Counter model: next count = `load_en ? data_in : count_out + 1`, taken mod 2^WIDTH, so 0x3FF+1 wraps to 0x000. The counter registers this one cycle after `load_en`/`data_in` are sampled.
- FSM states: IDLE, SYNC, CHECK.
  - IDLE to SYNC when `enable` = 1.
  - SYNC to CHECK unconditionally after one cycle. In SYNC, `exp` is loaded from the model applied to the current `count_out`/`load_en`/`data_in`.
  - CHECK: each cycle, compare `count_out` with `exp`.
  - Any state goes to IDLE when `enable` = 0. Re-enabling always passes through SYNC, so no check occurs in the first enabled cycle.
- Resync rule: in CHECK, the next `exp` is always computed from the actual `count_out`, not the previous `exp`. A single corrupted sample therefore produces exactly one error.
- On a mismatch in CHECK:
  - `err_count` increments, saturating at 0xFFFF.
  - An entry `{stamp, exp, count_out}` is pushed to the log.
  - If the log is full and no pop happens that cycle, the entry is dropped and `log_overflow` is set.
- `stamp` is a free-running 16-bit cycle counter, 0 at reset, that wraps.
- FIFO behaviour:
  - `log_rd_data` shows the head entry while not empty; its value is undefined while empty.
  - Push and pop in the same cycle: both happen. When full, the push is accepted and occupancy stays unchanged. When empty, only the push happens.
  - Pop when empty: no effect.
- Reset values:
  - FSM: IDLE. `exp`: 0. `stamp`: 0. `err_count`: 0.
  - `log_empty`: 1. `log_full`: 0. `log_overflow`: 0. `checking`: 0.
  - FIFO pointers cleared; stored contents are don't-care.
- Reset mid-operation discards all log contents and counts on the same edge.

## Timing

- Mismatch at the edge sampling cycle N: `err_count` updates, and `log_empty` falls (if the log was empty), both visible after edge N+1.
- Log read: `log_rd_data` is valid combinationally from memory and pointers. A pop at edge E advances the head, visible after E.
- `checking` is registered: it is 1 from the cycle after SYNC.
- No combinational path from `count_out` to any output.

## Structure

- Shared package `count_checker_pkg` holds:
  - FSM state encoding (`ST_IDLE`, `ST_SYNC`, `ST_CHECK`).
  - `STAMP_W` = 16 and `ERR_W` = 16.
  - Log entry field offsets.
- One sub-module: `sync_fifo` (parameters: width, depth), with show-ahead read, full/empty flags and simultaneous push/pop. The checker instantiates it once.

## Test plan

- Reset, `enable`=1, stimulus increments from 0 with `load_en`=0 for 20 cycles → `err_count`=0, `log_empty`=1, `checking`=1 from cycle 2.
- `load_en`=1 with `data_in`=0x155, counter correct → no error; the next cycle expects 0x156. Counter at 0x3FF with no load → 0x000 expected, no error.
- `count_out` forced to 0x0A0 when 0x005 was expected → `err_count`=1 and exactly one entry `{stamp, 0x005, 0x0A0}`. The following cycle expects 0x0A1 and raises no second error.
- LOG_DEPTH+2 consecutive mismatches with no reads → `log_full`=1, `log_overflow`=1, `err_count`=LOG_DEPTH+2. Draining returns the first LOG_DEPTH entries in order, after which `log_empty`=1.
- Full log with a mismatch and `log_rd_en` in the same cycle → the entry is accepted, `log_overflow` stays 0, `log_full` stays 1.
- `reset` asserted mid-run with errors logged → all outputs return to their reset values on the next edge. Drop `enable` for 3 cycles, then raise it → SYNC cycle, no false error on resume.
